// File: rtl/key_expand_seq_if.sv
// Handshake and data bundle between the AES-128 key schedule and its consumer.
interface key_expand_seq_if;
  logic         start;
  logic [127:0] ip_key;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, ip_key, key_ready,
    input  key_valid, round_key, round_idx, busy, done
  );

  modport slave (
    input  start, ip_key, key_ready,
    output key_valid, round_key, round_idx, busy, done
  );
endinterface

// File: rtl/key_expand_seq.sv
// Iterative AES-128 key schedule: round keys 0..10 delivered one per key_valid/key_ready handshake.
//  state | meaning
//  IDLE  | waiting for start; round_key/round_idx hold the last delivered key
//  RUN   | key_valid high; each accepted key advances to the next round key
//  DONE  | one-cycle done pulse after round 10 was accepted
module key_expand_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROUNDS = 10
) (
  input logic             clk,
  input logic             rst_n,
  key_expand_seq_if.slave bus
);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("key_expand_seq: DATA_WIDTH must be 8, got %0d", DATA_WIDTH);
  end
  if (NUM_ROUNDS != 10) begin : g_bad_num_rounds
    $error("key_expand_seq: NUM_ROUNDS must be 10, got %0d", NUM_ROUNDS);
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t       state, state_nxt;
  logic [127:0] key_q, key_nxt;
  logic [3:0]   idx_q, idx_nxt;
  logic [7:0]   rcon_q, rcon_nxt;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic         fire;

  // Word-generation datapath: RotWord, four S-box lookups, rcon, then the XOR chain.
  assign rot_w = {key_q[23:0], key_q[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_w[8*b +: 8] = SBOX[rot_w[8*b +: 8]];
  end

  assign t_w = sub_w ^ {rcon_q, 24'h0};
  assign n0  = key_q[127:96] ^ t_w;
  assign n1  = key_q[95:64]  ^ n0;
  assign n2  = key_q[63:32]  ^ n1;
  assign n3  = key_q[31:0]   ^ n2;

  // key_valid is high for the whole of RUN, so ready alone completes the handshake.
  assign fire = (state == RUN) && bus.key_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      key_q  <= '0;
      idx_q  <= '0;
      rcon_q <= 8'h01;
    end else begin
      state  <= state_nxt;
      key_q  <= key_nxt;
      idx_q  <= idx_nxt;
      rcon_q <= rcon_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_q;
    idx_nxt   = idx_q;
    rcon_nxt  = rcon_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          key_nxt   = bus.ip_key;
          idx_nxt   = '0;
          rcon_nxt  = 8'h01;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (fire) begin
          if (idx_q == LAST_IDX) begin
            state_nxt = DONE;
          end else begin
            key_nxt  = {n0, n1, n2, n3};
            idx_nxt  = idx_q + 4'd1;
            rcon_nxt = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.key_valid = (state == RUN);
    bus.busy      = (state == RUN);
    bus.done      = (state == DONE);
    bus.round_key = key_q;
    bus.round_idx = idx_q;
  end

endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: GF(2^8)-derived reference key schedule, random ready stalls and keys.
module tb_key_expand_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_expand_seq_if kx_if ();

  key_expand_seq #(.DATA_WIDTH(8), .NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kx_if)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_m   [256];
  logic [127:0] exp_keys [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gpow(input logic [7:0] a, input int n);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < n; i++) p = gmul(p, a);
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] b;
    logic [7:0] s;
    for (int v = 0; v < 256; v++) begin
      b = (v == 0) ? 8'h00 : gpow(8'(v), 254);
      s = b ^ 8'h63;
      for (int k = 1; k <= 4; k++) s = s ^ 8'((b << k) | (b >> (8 - k)));
      sbox_m[v] = s;
    end
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {gpow(8'h02, i/4 - 1), 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the DUT in IDLE; returns just after a negedge in IDLE.
  task automatic run(input string name, input logic [127:0] key, input int ready_pct,
                     input int start_at, input int abort_at, input bit has_kv,
                     input logic [127:0] kv1, input logic [127:0] kv10);
    int exp_idx;
    int cyc;
    bit finished;
    bit ready;
    build_model(key);
    kx_if.start     = 1'b1;
    kx_if.ip_key    = key;
    kx_if.key_ready = 1'b0;
    @(negedge clk);
    kx_if.start  = 1'b0;
    kx_if.ip_key = ~key;
    check({name, "_lat_valid"}, 128'(kx_if.key_valid), 128'd1);
    exp_idx  = 0;
    cyc      = 1;
    finished = 1'b0;
    while (!finished && cyc < 300) begin
      check({name, "_idx"},  128'(kx_if.round_idx), 128'(exp_idx));
      check({name, "_key"},  kx_if.round_key, exp_keys[exp_idx]);
      check({name, "_busy"}, 128'(kx_if.busy), 128'd1);
      if (has_kv && exp_idx == 1)  check({name, "_known_k1"}, kx_if.round_key, kv1);
      if (has_kv && exp_idx == 10) check({name, "_known_k10"}, kx_if.round_key, kv10);
      if (ready_pct == 100 && exp_idx == 10) check({name, "_k10_cycle"}, 128'(cyc), 128'd11);
      if (exp_idx == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check({name, "_rst_valid"}, 128'(kx_if.key_valid), 128'd0);
        check({name, "_rst_busy"},  128'(kx_if.busy), 128'd0);
        check({name, "_rst_key"},   kx_if.round_key, 128'd0);
        check({name, "_rst_idx"},   128'(kx_if.round_idx), 128'd0);
        rst_n = 1'b1;
        return;
      end
      kx_if.start  = (exp_idx == start_at);
      kx_if.ip_key = {$urandom, $urandom, $urandom, $urandom};
      ready = ($urandom_range(0, 99) < ready_pct);
      kx_if.key_ready = ready;
      @(negedge clk);
      cyc++;
      kx_if.start = 1'b0;
      if (ready) begin
        if (exp_idx == 10) finished = 1'b1;
        else exp_idx++;
      end
    end
    check({name, "_timeout"}, 128'(finished), 128'd1);
    kx_if.key_ready = 1'b0;
    check({name, "_done_pulse"}, 128'(kx_if.done), 128'd1);
    check({name, "_done_busy"},  128'(kx_if.busy), 128'd0);
    check({name, "_done_valid"}, 128'(kx_if.key_valid), 128'd0);
    if (ready_pct == 100) check({name, "_done_cycle"}, 128'(cyc), 128'd12);
    @(negedge clk);
    check({name, "_done_clear"}, 128'(kx_if.done), 128'd0);
    check({name, "_hold_key"},   kx_if.round_key, exp_keys[10]);
    check({name, "_hold_idx"},   128'(kx_if.round_idx), 128'd10);
  endtask

  initial begin
    rst_n           = 1'b0;
    kx_if.start     = 1'b0;
    kx_if.ip_key    = '0;
    kx_if.key_ready = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    check("reset_valid", 128'(kx_if.key_valid), 128'd0);
    check("reset_busy",  128'(kx_if.busy), 128'd0);
    check("reset_done",  128'(kx_if.done), 128'd0);
    check("reset_key",   kx_if.round_key, 128'd0);
    check("reset_idx",   128'(kx_if.round_idx), 128'd0);
    rst_n = 1'b1;
    kx_if.key_ready = 1'b1;
    @(negedge clk);
    check("idle_no_start", 128'(kx_if.key_valid), 128'd0);

    run("t1_fips",   FIPS_KEY, 100, -1, -1, 1'b1, FIPS_K1, FIPS_K10);
    run("t2_zero",   128'd0,   100, -1, -1, 1'b1, ZERO_K1, ZERO_K10);
    run("t3_stall",  FIPS_KEY, 50,  -1, -1, 1'b1, FIPS_K1, FIPS_K10);
    run("t4_start5", FIPS_KEY, 70,  5,  -1, 1'b1, FIPS_K1, FIPS_K10);
    run("t5_abort",  FIPS_KEY, 100, -1, 4,  1'b0, '0, '0);
    run("t5_fresh",  FIPS_KEY, 60,  -1, -1, 1'b1, FIPS_K1, FIPS_K10);
    run("t6_first",  FIPS_KEY, 100, -1, -1, 1'b1, FIPS_K1, FIPS_K10);
    run("t6_second", 128'd0,   100, -1, -1, 1'b1, ZERO_K1, ZERO_K10);
    for (int i = 0; i < 4; i++) begin
      run("rand_key", {$urandom, $urandom, $urandom, $urandom}, 75, -1, -1, 1'b0, '0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
